keypress_encoder: RTL and testbench
===================================

# keypress_encoder

Converts the USB HID keyboard report stream, delivered one keycode per strobe from the USB/NIOS side, into the 8-bit held-key vector `keypress` consumed by the player movement blocks. It frames six-slot reports, decodes each slot against a fixed key map, and commits the whole vector atomically at end of report. It also emits one-cycle press pulses and optionally clears stale keys when reports stop arriving. It sits between the USB keyboard interface and `player1` / `player2`.

## Interface
- `TIMEOUT_FRAMES`, 30: frame_clk rising edges without a committed report before keys are cleared (1..63).
- `Clk`  in  1  system clock; single clock domain.
- `Reset`  in  1  synchronous, active-high reset.
- `frame_clk`  in  1  vertical-sync frame tick, asynchronous level; edge-detected internally.
- `report_start`  in  1  one-cycle pulse marking slot 0 of a new report.
- `key_valid`  in  1  keycode strobe; one slot per asserted cycle.
- `keycode`  in  8  HID usage code for the current slot.
- `keypress`  out  8  committed held-key vector.
- `press_pulse`  out  8  one-cycle rising-edge flags of `keypress`.
- `rpt_drop`  out  1  one-cycle pulse when a report is discarded.

## Operation
- Key map (HID usage -> bit): 0x1A W -> 7, 0x04 A -> 6, 0x07 D -> 5, 0x09 F -> 4 (player 1 punch); 0x52 Up -> 3, 0x50 Left -> 2, 0x4F Right -> 1, 0x38 '/' -> 0 (player 2 punch). Other codes, including 0x00, set no bit. Duplicate codes are OR-ed together.
- FSM states:
  - IDLE: ignores `key_valid`.
  - COLLECT: 3-bit slot counter 0..5 plus 8-bit shadow vector.
  - SWALLOW: the report is poisoned and the remaining slots are ignored.
- Transitions:
  - `report_start` in any state: slot <- 0, shadow <- 0, poison cleared, state -> COLLECT.
  - If `key_valid` is also high in that cycle, its keycode is slot 0 and is counted.
  - A mid-report `report_start` discards the partial report without a `rpt_drop` pulse.
- COLLECT with `key_valid`:
  - If `keycode` is 0x01 (rollover error), state -> SWALLOW.
  - Otherwise shadow |= decode(keycode) and slot increments.
  - On slot 5: `keypress` <= shadow | decode(keycode), state -> IDLE. This commit applies even if all keys are released (vector 0).
- SWALLOW: counts slots; at slot 5 it pulses `rpt_drop`, leaves `keypress` unchanged, and goes to IDLE.
- `key_valid` in IDLE (more than 6 slots, or no start): ignored, pulses `rpt_drop`.
- `press_pulse` = next `keypress` & ~current `keypress`; asserted only on the commit/clear cycle, and 0 otherwise.
- No left/right arbitration is done; simultaneous opposing bits are passed through. Priority is resolved by the consumer.

## Timing
- Reset values: `keypress`=0, `press_pulse`=0, `rpt_drop`=0, state IDLE, slot 0, shadow 0, timeout counter 0, frame edge flops 0.
- Latency: `keypress` and `press_pulse` update on the `Clk` edge that samples the sixth `key_valid`, so they are visible in the following cycle.
- `rpt_drop` has the same 1-cycle registered latency.
- `frame_clk` passes through two flops; a rising edge is detected when the second stage is 0 and the first is 1, giving a 2–3 `Clk` delay.
- Reset asserted mid-report aborts it completely; no partial commit occurs.

## Configuration
- `KEYPRESS_TIMEOUT_EN` defined: a 6-bit counter increments on each detected frame_clk rising edge and is zeroed on every commit.
  - When it reaches `TIMEOUT_FRAMES`, `keypress` <= 0, `press_pulse` = 0 that cycle, and the counter holds until the next commit.
  - If a commit and a timeout fall in the same cycle, the commit wins.
  - Discarded reports do not reset the counter.
- Undefined: no counter exists; `keypress` holds the last committed value indefinitely.

## Test plan
- Sequence: start + slots {0x04,0,0,0,0,0}.
  - Required: `keypress`=0x40 one cycle after the 6th strobe.
  - Required: `press_pulse`=0x40 for exactly 1 cycle.
- Sequence: next report {0x07,0x09,0x04,0,0,0}.
  - Required: `keypress`=0x70.
  - Required: `press_pulse`=0x30.
- Sequence: report with 0x01 in slot 2.
  - Required: `keypress` unchanged at 0x70.
  - Required: `rpt_drop` pulses once, after slot 5.
- Sequence: `report_start` after 3 slots, then a full report {0x52,0x38,0,0,0,0}.
  - Required: `keypress`=0x09, with no `rpt_drop`.
  - Variant: `report_start` coincident with `key_valid`; that keycode is counted as slot 0.
- Sequence: 7th strobe without start.
  - Required: `rpt_drop`=1 for 1 cycle, `keypress` unchanged.
- With `KEYPRESS_TIMEOUT_EN` and `TIMEOUT_FRAMES`=3: commit 0x40, then 3 frame edges with no report.
  - Required: `keypress`=0.
  - Required: `Reset` mid-report gives all outputs 0.

Source files
------------

// File: rtl/keypress_encoder.sv
// keypress_encoder: frames six-slot USB HID keyboard reports (one keycode per
// key_valid strobe), decodes each slot against the fixed game key map and
// commits the held-key vector atomically at the end of every report.
// Optional stale-key clearing is built when KEYPRESS_TIMEOUT_EN is defined:
// after TIMEOUT_FRAMES frame ticks without a committed report the vector is
// forced to zero.
module keypress_encoder #(
  parameter int unsigned TIMEOUT_FRAMES = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       report_start,
  input  logic       key_valid,
  input  logic [7:0] keycode,
  output logic [7:0] keypress,
  output logic [7:0] press_pulse,
  output logic       rpt_drop
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] SWALLOW = 2'd2;

  localparam logic [2:0] LAST_SLOT     = 3'd5;
  localparam logic [7:0] ROLLOVER_CODE = 8'h01;
  localparam logic [5:0] TIMEOUT_LIMIT = 6'(TIMEOUT_FRAMES);

  logic [1:0] state_q, state_d;
  logic [2:0] slot_q, slot_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] keypress_q, keypress_d;
  logic [7:0] press_pulse_q, press_pulse_d;
  logic       rpt_drop_q, rpt_drop_d;
  logic       frame_meta_q, frame_sync_q;

  logic       frame_rise;
  logic       commit;
  logic [1:0] cur_state;
  logic [2:0] cur_slot;
  logic [7:0] cur_shadow;
  logic [7:0] slot_bits;

  // Map one HID usage code onto its bit in the held-key vector
  function automatic logic [7:0] decode(input logic [7:0] code);
    logic [7:0] bits;
    bits = 8'h00;
    case (code)
      8'h1A:   bits = 8'h80;
      8'h04:   bits = 8'h40;
      8'h07:   bits = 8'h20;
      8'h09:   bits = 8'h10;
      8'h52:   bits = 8'h08;
      8'h50:   bits = 8'h04;
      8'h4F:   bits = 8'h02;
      8'h38:   bits = 8'h01;
      default: bits = 8'h00;
    endcase
    return bits;
  endfunction

  assign frame_rise = frame_meta_q & ~frame_sync_q;
  assign slot_bits  = decode(keycode);

`ifdef KEYPRESS_TIMEOUT_EN
  logic [5:0] timeout_cnt_q, timeout_cnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{frame_rise, commit, TIMEOUT_LIMIT};
`endif

  // Report framing, slot decoding, commit and stale-key clearing
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    shadow_d   = shadow_q;
    keypress_d = keypress_q;
    rpt_drop_d = 1'b0;
    commit     = 1'b0;
    cur_state  = state_q;
    cur_slot   = slot_q;
    cur_shadow = shadow_q;

    if (report_start) begin
      cur_state  = COLLECT;
      cur_slot   = 3'd0;
      cur_shadow = 8'h00;
      state_d    = COLLECT;
      slot_d     = 3'd0;
      shadow_d   = 8'h00;
    end

    if (key_valid) begin
      case (cur_state)
        COLLECT: begin
          if (keycode == ROLLOVER_CODE) begin
            if (cur_slot == LAST_SLOT) begin
              state_d    = IDLE;
              slot_d     = 3'd0;
              rpt_drop_d = 1'b1;
            end else begin
              state_d = SWALLOW;
              slot_d  = cur_slot + 3'd1;
            end
          end else if (cur_slot == LAST_SLOT) begin
            keypress_d = cur_shadow | slot_bits;
            commit     = 1'b1;
            state_d    = IDLE;
            slot_d     = 3'd0;
            shadow_d   = 8'h00;
          end else begin
            shadow_d = cur_shadow | slot_bits;
            slot_d   = cur_slot + 3'd1;
          end
        end
        SWALLOW: begin
          if (cur_slot == LAST_SLOT) begin
            state_d    = IDLE;
            slot_d     = 3'd0;
            rpt_drop_d = 1'b1;
          end else begin
            slot_d = cur_slot + 3'd1;
          end
        end
        default: begin
          rpt_drop_d = 1'b1;
        end
      endcase
    end

`ifdef KEYPRESS_TIMEOUT_EN
    timeout_cnt_d = timeout_cnt_q;
    if (commit) begin
      timeout_cnt_d = 6'd0;
    end else if (frame_rise && (timeout_cnt_q != TIMEOUT_LIMIT)) begin
      timeout_cnt_d = timeout_cnt_q + 6'd1;
      if ((timeout_cnt_q + 6'd1) == TIMEOUT_LIMIT) begin
        keypress_d = 8'h00;
      end
    end
`endif

    press_pulse_d = keypress_d & ~keypress_q;
  end

  // State, vector and frame-tick synchroniser registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      slot_q        <= 3'd0;
      shadow_q      <= 8'h00;
      keypress_q    <= 8'h00;
      press_pulse_q <= 8'h00;
      rpt_drop_q    <= 1'b0;
      frame_meta_q  <= 1'b0;
      frame_sync_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      keypress_q    <= keypress_d;
      press_pulse_q <= press_pulse_d;
      rpt_drop_q    <= rpt_drop_d;
      frame_meta_q  <= frame_clk;
      frame_sync_q  <= frame_meta_q;
    end
  end

`ifdef KEYPRESS_TIMEOUT_EN
  // Frames elapsed since the last committed report
  always_ff @(posedge Clk) begin
    if (Reset) begin
      timeout_cnt_q <= 6'd0;
    end else begin
      timeout_cnt_q <= timeout_cnt_d;
    end
  end
`endif

  assign keypress    = keypress_q;
  assign press_pulse = press_pulse_q;
  assign rpt_drop    = rpt_drop_q;

endmodule

// File: tb/tb_keypress_encoder.sv
// tb_keypress_encoder: scoreboard bench for keypress_encoder. Stimulus tasks
// predict every visible output event (commit with a changed vector, dropped
// report, timeout clear) and queue it; a negedge monitor pops and compares
// whenever the DUT shows activity. Timeout checks are built with
// KEYPRESS_TIMEOUT_EN.
module tb_keypress_encoder;

`ifdef KEYPRESS_TIMEOUT_EN
  localparam int TB_TIMEOUT = 3;
`else
  localparam int TB_TIMEOUT = 30;
`endif

  typedef struct {
    logic [7:0] kp;
    logic [7:0] pulse;
    logic       drop;
    int         cyc;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       report_start = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [7:0] keypress;
  logic [7:0] press_pulse;
  logic       rpt_drop;

  int         checks = 0;
  int         failures = 0;
  int         cycle_cnt = 0;
  bit         mon_en = 1'b0;
  logic [7:0] mon_last_kp;
  logic [7:0] model_kp = 8'h00;
  exp_t       exp_q [$];

  // Index of each entry is the vector bit that key sets
  logic [7:0] key_map [8] = '{8'h38, 8'h4F, 8'h50, 8'h52, 8'h09, 8'h07, 8'h04, 8'h1A};

  keypress_encoder #(.TIMEOUT_FRAMES(TB_TIMEOUT)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_clk(frame_clk),
    .report_start(report_start),
    .key_valid(key_valid),
    .keycode(keycode),
    .keypress(keypress),
    .press_pulse(press_pulse),
    .rpt_drop(rpt_drop)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cycle_cnt <= cycle_cnt + 1;

  function automatic logic [7:0] model_decode(input logic [7:0] code);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 0; b < 8; b++) begin
      if (code == key_map[b]) r[b] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [7:0] rand_code();
    int r;
    r = int'($urandom_range(0, 15));
    if (r < 8) return key_map[r];
    if (r < 12) return 8'h00;
    return 8'($urandom_range(8'h60, 8'hFF));
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycle_cnt);
    end
  endtask

  // Drive one clock cycle of inputs; returns #1 after the sampling edge
  task automatic apply_stimulus(input logic start, input logic valid, input logic [7:0] code);
    report_start = start;
    key_valid    = valid;
    keycode      = code;
    @(posedge Clk);
    #1;
    report_start = 1'b0;
    key_valid    = 1'b0;
    keycode      = 8'h00;
  endtask

  task automatic push_event(input logic [7:0] kp, input logic [7:0] pulse, input logic drop, input int cyc);
    exp_t e;
    e.kp = kp;
    e.pulse = pulse;
    e.drop = drop;
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // Full six-slot report; the expected outcome is derived from the slot list
  task automatic send_report(input logic [7:0] codes [6], input bit coincident);
    logic [7:0] acc;
    bit poisoned;
    acc = 8'h00;
    poisoned = 1'b0;
    if (!coincident) apply_stimulus(1'b1, 1'b0, 8'h00);
    for (int s = 0; s < 6; s++) begin
      if (s > 0 && $urandom_range(0, 3) == 0) apply_stimulus(1'b0, 1'b0, 8'h00);
      apply_stimulus(coincident && s == 0, 1'b1, codes[s]);
      if (codes[s] == 8'h01) poisoned = 1'b1;
      acc |= model_decode(codes[s]);
    end
    if (poisoned) begin
      push_event(model_kp, 8'h00, 1'b1, cycle_cnt);
    end else begin
      if (acc != model_kp) push_event(acc, acc & ~model_kp, 1'b0, cycle_cnt);
      model_kp = acc;
    end
  endtask

  task automatic send_partial(input int n, input bit coincident);
    if (!coincident) apply_stimulus(1'b1, 1'b0, 8'h00);
    for (int s = 0; s < n; s++) apply_stimulus(coincident && s == 0, 1'b1, rand_code());
  endtask

  task automatic stray_strobe();
    apply_stimulus(1'b0, 1'b1, rand_code());
    push_event(model_kp, 8'h00, 1'b1, cycle_cnt);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: any visible activity must match the next predicted event
  always @(negedge Clk) begin
    exp_t e;
    if (mon_en && (rpt_drop !== 1'b0 || press_pulse !== 8'h00 || keypress !== mon_last_kp)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_output: keypress=0x%0h press_pulse=0x%0h rpt_drop=%0b with no event expected (cycle %0d)",
                 keypress, press_pulse, rpt_drop, cycle_cnt);
      end else begin
        e = exp_q.pop_front();
        check_output("keypress", 32'(keypress), 32'(e.kp));
        check_output("press_pulse", 32'(press_pulse), 32'(e.pulse));
        check_output("rpt_drop", 32'(rpt_drop), 32'(e.drop));
        check_output("event_cycle", 32'(cycle_cnt), 32'(e.cyc));
      end
    end
    mon_last_kp = keypress;
  end

  initial begin
    logic [7:0] codes [6];
    int sel;
    int pos;

    $display("[TB] keypress_encoder scoreboard run, timeout frames %0d", TB_TIMEOUT);

    // Reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_output("reset_keypress", 32'(keypress), 32'h0);
    check_output("reset_press_pulse", 32'(press_pulse), 32'h0);
    check_output("reset_rpt_drop", 32'(rpt_drop), 32'h0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    mon_en = 1'b1;
    idle_cycles(2);

    // Directed sequences from the key map
    codes = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_report(codes, 1'b0);
    idle_cycles(2);
    codes = '{8'h07, 8'h09, 8'h04, 8'h00, 8'h00, 8'h00};
    send_report(codes, 1'b0);
    idle_cycles(2);
    codes = '{8'h52, 8'h1A, 8'h01, 8'h38, 8'h00, 8'h00};
    send_report(codes, 1'b0);
    idle_cycles(2);
    send_partial(3, 1'b0);
    codes = '{8'h52, 8'h38, 8'h00, 8'h00, 8'h00, 8'h00};
    send_report(codes, 1'b0);
    idle_cycles(2);
    send_partial(2, 1'b1);
    codes = '{8'h1A, 8'h50, 8'h4F, 8'h1A, 8'h00, 8'h00};
    send_report(codes, 1'b1);
    stray_strobe();
    idle_cycles(2);
    codes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_report(codes, 1'b0);
    idle_cycles(2);

    // Randomised report stream
    for (int it = 0; it < 150; it++) begin
      sel = int'($urandom_range(0, 9));
      for (int s = 0; s < 6; s++) codes[s] = rand_code();
      if (sel <= 4) begin
        send_report(codes, 1'($urandom_range(0, 1)));
      end else if (sel <= 6) begin
        pos = int'($urandom_range(0, 4));
        codes[pos] = 8'h01;
        send_report(codes, 1'($urandom_range(0, 1)));
      end else if (sel == 7) begin
        send_partial(int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
        send_report(codes, 1'($urandom_range(0, 1)));
      end else if (sel == 8) begin
        stray_strobe();
      end else begin
        idle_cycles(int'($urandom_range(1, 4)));
      end
    end
    idle_cycles(3);

`ifdef KEYPRESS_TIMEOUT_EN
    // Stale keys cleared after TIMEOUT_FRAMES frame ticks without a commit
    codes = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_report(codes, 1'b0);
    idle_cycles(3);
    for (int f = 0; f < TB_TIMEOUT; f++) begin
      frame_clk = 1'b1;
      if (f == TB_TIMEOUT - 1) begin
        push_event(8'h00, 8'h00, 1'b0, cycle_cnt + 2);
        model_kp = 8'h00;
      end
      idle_cycles(3);
      frame_clk = 1'b0;
      idle_cycles(3);
    end
    idle_cycles(3);
    check_output("timeout_keypress", 32'(keypress), 32'h0);
`endif

    // Reset in the middle of a report aborts it with nothing committed
    codes = '{8'h4F, 8'h52, 8'h00, 8'h00, 8'h00, 8'h00};
    send_report(codes, 1'b0);
    idle_cycles(3);
    check_output("pending_before_reset", 32'(exp_q.size()), 32'h0);
    send_partial(3, 1'b0);
    mon_en = 1'b0;
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    check_output("midreset_keypress", 32'(keypress), 32'h0);
    check_output("midreset_press_pulse", 32'(press_pulse), 32'h0);
    check_output("midreset_rpt_drop", 32'(rpt_drop), 32'h0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_kp = 8'h00;
    @(negedge Clk);
    mon_en = 1'b1;
    @(posedge Clk);
    #1;
    stray_strobe();
    stray_strobe();
    stray_strobe();
    idle_cycles(2);
    codes = '{8'h4F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_report(codes, 1'b0);
    idle_cycles(4);

    check_output("final_keypress", 32'(keypress), 32'(model_kp));
    check_output("pending_events", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
